// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared constants for the unified-memory port arbiter.
//   - FSM state encoding (IDLE / ACCESS / RESP)
//   - Port identifiers (CPU = port 0, AUX = port 1)
//   - Wait-state counter width, sized for WAIT_CYC up to 15
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACCESS = 2'b01;
  localparam logic [1:0] RESP   = 2'b10;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam int CNT_W = 4;

endpackage : mem_arb_pkg

// File: rtl/arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner selection between the two memory requesters.
// Build option: MEM_ARB_ROUND_ROBIN_EN
//   undefined - fixed priority, port 0 wins ties
//   defined   - ties go to the port that did not own the previous transaction
// Ports:
//   m0_req, m1_req : requests from port 0 (CPU) and port 1 (AUX)
//   last_owner     : previous owner (round-robin build only)
//   pick           : winning port id, meaningful when either req is high
// -----------------------------------------------------------------------------
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic m0_req,
  input  logic m1_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic last_owner,
`endif
  output logic pick
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // A lone requester always wins; on a tie the previous owner yields.
  assign pick = (m0_req && m1_req) ? ~last_owner
              : (m1_req ? PORT_AUX : PORT_CPU);
`else
  assign pick = (m1_req && !m0_req) ? PORT_AUX : PORT_CPU;
`endif

endmodule : arb_pick

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the CPU's unified instruction/data memory between the CPU port (0)
// and an auxiliary master (1). One transaction at a time: IDLE -> ACCESS for
// WAIT_CYC+1 cycles -> RESP (one-cycle ack) -> IDLE.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// (default: fixed priority, port 0 wins).
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   mN_req/we/addr/wdata      : port N request, held until mN_ack
//   mN_rdata, mN_ack          : shared read data, one-cycle completion pulse
//   mem_en/we/addr/wdata      : memory array interface (driven in ACCESS)
//   mem_rdata                 : memory read data, valid in last ACCESS cycle
//   grant                     : owner of current or last transaction
//   busy                      : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant,
  output logic              busy
);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              grant_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              pick;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_owner;

  arb_pick u_pick (
    .m0_req     (m0_req),
    .m1_req     (m1_req),
    .last_owner (last_owner),
    .pick       (pick)
  );

  // Starts at port 1 so the very first tie goes to the CPU.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= PORT_AUX;
    end else if (state == IDLE && (m0_req || m1_req)) begin
      last_owner <= pick;
    end
  end
`else
  arb_pick u_pick (
    .m0_req (m0_req),
    .m1_req (m1_req),
    .pick   (pick)
  );
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      grant_q <= PORT_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Winner's fields are frozen here; later requester changes are ignored.
          if (m0_req || m1_req) begin
            state   <= ACCESS;
            cnt     <= CNT_W'(WAIT_CYC);
            grant_q <= pick;
            we_q    <= pick ? m1_we    : m0_we;
            addr_q  <= pick ? m1_addr  : m0_addr;
            wdata_q <= pick ? m1_wdata : m0_wdata;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state <= RESP;
            if (!we_q) begin
              rdata_q <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          // Requests are not sampled here, guaranteeing an IDLE gap.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign m0_ack    = (state == RESP) && (grant_q == PORT_CPU);
  assign m1_ack    = (state == RESP) && (grant_q == PORT_AUX);
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;

  assign grant     = grant_q;
  assign busy      = (state != IDLE);

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Two instances: u_dut (WAIT_CYC=2) and
// u_dut_zw (WAIT_CYC=0). Cycle c of a scenario is sampled 1 time unit after
// the c-th rising edge following the cycle in which the request was raised.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic        m0_ack, m1_ack, mem_en, mem_we, grant, busy;

  logic        z_m0_req = 0, z_m1_req = 0;
  logic [31:0] z_m0_addr = 0, z_mem_rdata = 0;
  logic [31:0] z_m0_rdata, z_m1_rdata, z_mem_addr, z_mem_wdata;
  logic        z_m0_ack, z_m1_ack, z_mem_en, z_mem_we, z_grant, z_busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(2)) u_dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .grant(grant), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(0)) u_dut_zw (
    .clk(clk), .reset(reset),
    .m0_req(z_m0_req), .m0_we(1'b0), .m0_addr(z_m0_addr), .m0_wdata(32'h0),
    .m0_rdata(z_m0_rdata), .m0_ack(z_m0_ack),
    .m1_req(z_m1_req), .m1_we(1'b0), .m1_addr(32'h0), .m1_wdata(32'h0),
    .m1_rdata(z_m1_rdata), .m1_ack(z_m1_ack),
    .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr),
    .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata),
    .grant(z_grant), .busy(z_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at cycle 0 of the next scenario with the DUTs in IDLE.
  task automatic do_reset();
    step();
    reset = 1'b1;
    m0_req = 0; m1_req = 0; z_m0_req = 0; z_m1_req = 0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    tests_run++;
    if ({mem_en, mem_we, m0_ack, m1_ack, busy, grant} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {mem_en, mem_we, m0_ack, m1_ack, busy, grant});
    end
    tests_run++;
    if ({m0_rdata, mem_addr, mem_wdata} !== 96'h0) begin
      tests_failed++;
      $display("FAIL reset_regs: got rdata=%h addr=%h wdata=%h expected all 0",
               m0_rdata, mem_addr, mem_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) step();
      mem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0BAD_F00D;
      tests_run++;
      if ({mem_en, m0_ack, m1_ack} !== {(c >= 1 && c <= 3), (c == 4), 1'b0}) begin
        tests_failed++;
        $display("FAIL read_seq c%0d: got en/ack0/ack1=%b%b%b expected %b%b0",
                 c, mem_en, m0_ack, m1_ack, (c >= 1 && c <= 3), (c == 4));
      end
      if (c == 2) begin
        tests_run++;
        if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin
          tests_failed++;
          $display("FAIL read_addr: got addr=%h we=%b expected 00000010/0",
                   mem_addr, mem_we);
        end
      end
      if (c == 4) begin
        tests_run++;
        if (m0_rdata !== 32'hDEAD_BEEF) begin
          tests_failed++;
          $display("FAIL read_data: got %h expected deadbeef", m0_rdata);
        end
        m0_req = 0;
      end
    end
  endtask

  // Runs directly after the read: rdata must still hold DEADBEEF.
  task automatic test_single_write();
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h1234_5678;
    mem_rdata = 32'h5555_5555;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) step();
      if (c == 1) begin
        m1_addr = 32'hFC; m1_wdata = 32'h0;
      end
      if (c >= 1 && c <= 3) begin
        tests_run++;
        if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h20 ||
            mem_wdata !== 32'h1234_5678) begin
          tests_failed++;
          $display("FAIL write_bus c%0d: got en=%b we=%b addr=%h data=%h expected 1 1 00000020 12345678",
                   c, mem_en, mem_we, mem_addr, mem_wdata);
        end
      end else begin
        tests_run++;
        if (mem_we !== 1'b0) begin
          tests_failed++;
          $display("FAIL write_we_idle c%0d: got %b expected 0", c, mem_we);
        end
      end
      tests_run++;
      if ({m1_ack, m0_ack} !== {(c == 4), 1'b0}) begin
        tests_failed++;
        $display("FAIL write_ack c%0d: got ack1/ack0=%b%b expected %b0",
                 c, m1_ack, m0_ack, (c == 4));
      end
      if (c == 4) begin
        tests_run++;
        if (m1_rdata !== 32'hDEAD_BEEF || grant !== 1'b1) begin
          tests_failed++;
          $display("FAIL write_rdata_grant: got rdata=%h grant=%b expected deadbeef 1",
                   m1_rdata, grant);
        end
        m1_req = 0; m1_we = 0;
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h100;
    m1_req = 1; m1_we = 0; m1_addr = 32'h200;
    mem_rdata = 32'h0;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) step();
      tests_run++;
      if ({mem_en, m0_ack, m1_ack} !==
          {((c >= 1 && c <= 3) || (c >= 6 && c <= 8)), (c == 4), (c == 9)}) begin
        tests_failed++;
        $display("FAIL simul_seq c%0d: got en/ack0/ack1=%b%b%b expected %b%b%b", c,
                 mem_en, m0_ack, m1_ack,
                 ((c >= 1 && c <= 3) || (c >= 6 && c <= 8)), (c == 4), (c == 9));
      end
      if (c == 2 || c == 7) begin
        tests_run++;
        if (grant !== (c == 7) || mem_addr !== ((c == 7) ? 32'h200 : 32'h100)) begin
          tests_failed++;
          $display("FAIL simul_grant c%0d: got grant=%b addr=%h expected %b %h", c,
                   grant, mem_addr, (c == 7), ((c == 7) ? 32'h200 : 32'h100));
        end
      end
      if (c == 5) begin
        tests_run++;
        if (busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL simul_gap: got busy=%b expected 0", busy);
        end
      end
      if (c == 4) m0_req = 0;
      if (c == 9) m1_req = 0;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_grant;
    int         n;
    int         prev;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_grant = 4'b1010;
`else
    exp_grant = 4'b0000;
`endif
    n = 0;
    prev = 0;
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h300;
    m1_req = 1; m1_we = 0; m1_addr = 32'h400;
    for (int c = 0; c <= 25 && n < 4; c++) begin
      if (c > 0) step();
      if (m0_ack || m1_ack) begin
        tests_run++;
        if (m0_ack && m1_ack) begin
          tests_failed++;
          $display("FAIL b2b_both_ack c%0d: got 11 expected one-hot", c);
        end
        tests_run++;
        if (m1_ack !== exp_grant[n] || (c - prev) != ((n == 0) ? 4 : 5)) begin
          tests_failed++;
          $display("FAIL b2b_txn%0d: got port=%b gap=%0d expected port=%b gap=%0d",
                   n, m1_ack, c - prev, exp_grant[n], (n == 0) ? 4 : 5);
        end
        prev = c;
        n++;
      end
    end
    tests_run++;
    if (n != 4) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d acks expected 4", n);
    end
    m0_req = 0; m1_req = 0;
    step();
    step();
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'hA5A5_A5A5;
    step();
    step();
    tests_run++;
    if (mem_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_pre: got mem_en=%b expected 1", mem_en);
    end
    reset = 1'b1;
    m0_req = 0;
    step();
    tests_run++;
    if ({mem_en, mem_we, busy, m0_ack, m1_ack} !== 5'b0 || m0_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL midrst_state: got en/we/busy/ack0/ack1=%b rdata=%h expected 00000 0",
               {mem_en, mem_we, busy, m0_ack, m1_ack}, m0_rdata);
    end
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      tests_run++;
      if (m0_ack !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL midrst_noack c%0d: got ack=%b busy=%b expected 0 0", c, m0_ack, busy);
      end
    end
    m0_req = 1; m0_we = 0; m0_addr = 32'h44;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) step();
      mem_rdata = (c == 3) ? 32'h1357_9BDF : 32'h0;
      tests_run++;
      if (m0_ack !== (c == 4)) begin
        tests_failed++;
        $display("FAIL midrst_retry c%0d: got ack=%b expected %b", c, m0_ack, (c == 4));
      end
      if (c == 4) begin
        tests_run++;
        if (m0_rdata !== 32'h1357_9BDF) begin
          tests_failed++;
          $display("FAIL midrst_rdata: got %h expected 13579bdf", m0_rdata);
        end
        m0_req = 0;
      end
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    z_m0_req = 1; z_m0_addr = 32'h8;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) step();
      z_mem_rdata = (c == 1) ? 32'hCAFE_F00D : 32'h1111_1111;
      tests_run++;
      if ({z_mem_en, z_m0_ack, z_m1_ack} !== {(c == 1), (c == 2), 1'b0}) begin
        tests_failed++;
        $display("FAIL zw_seq c%0d: got en/ack0/ack1=%b%b%b expected %b%b0",
                 c, z_mem_en, z_m0_ack, z_m1_ack, (c == 1), (c == 2));
      end
      if (c == 2) begin
        tests_run++;
        if (z_m0_rdata !== 32'hCAFE_F00D) begin
          tests_failed++;
          $display("FAIL zw_rdata: got %h expected cafef00d", z_m0_rdata);
        end
        z_m0_req = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_access();
    test_zero_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multi-cycle CPU between two requesters.
- Port 0 is the CPU memory interface (fetch, load, store). Port 1 is an auxiliary master (program loader or debug).
- Serialises accesses, applies a fixed number of memory wait states, and returns a one-cycle ack per transaction.
- Sits between the CPU datapath/control and the memory array.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_CYC, 2, extra memory cycles per access (legal range 0..15). Access phase lasts WAIT_CYC+1 cycles.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  port 0 transaction request; held until m0_ack.
- m0_we  in  1  port 0 write enable (1=store, 0=load).
- m0_addr  in  ADDR_W  port 0 address.
- m0_wdata  in  DATA_W  port 0 write data.
- m0_rdata  out  DATA_W  port 0 read data; valid when m0_ack=1.
- m0_ack  out  1  port 0 completion pulse, one cycle.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  same directions, widths and meanings for port 1.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the last access cycle.
- grant  out  1  owner of the current or last transaction (0=port 0, 1=port 1).
- busy  out  1  high while state is not IDLE.

Behaviour:
- **FSM**
  - IDLE -> ACCESS when any req=1.
  - ACCESS holds for WAIT_CYC+1 cycles, then -> RESP.
  - RESP lasts one cycle, then -> IDLE.
  - RESP ignores req, so there is at least one IDLE cycle between transactions.
- **Grant latch** (on IDLE->ACCESS edge): latches grant, we, addr and wdata of the winner into registers. Requester changes after grant have no effect.
- **ACCESS outputs**
  - mem_en=1; mem_we = latched we; mem_addr and mem_wdata are the latched values.
  - Outside ACCESS: mem_en=0, mem_we=0.
- **Wait counter**: loads WAIT_CYC on entry to ACCESS and decrements each cycle. ACCESS exits when the count is 0.
  - WAIT_CYC=0 gives a single ACCESS cycle.
- **Read capture**: on a read, mem_rdata is captured into a shared rdata register in the last ACCESS cycle.
  - Writes leave the register unchanged.
  - m0_rdata and m1_rdata both drive from this register; each is meaningful only with its own ack.
- **Ack**: in RESP, ack[grant]=1 and the other ack=0. Acks are never asserted outside RESP.
- **Latency**: req seen in IDLE at cycle 0 -> ACCESS in cycles 1..WAIT_CYC+1 -> ack in cycle WAIT_CYC+2 (cycle 4 at default).
- **Back-to-back**: a requester may keep req high after ack with new fields. It is re-arbitrated in the next IDLE cycle.
- **Arbitration (default, macro absent)**: fixed priority; port 0 wins on simultaneous requests.
- **Reset (synchronous)**
  - state=IDLE, mem_en=0, mem_we=0, m0_ack=0, m1_ack=0, busy=0, grant=0, counter=0.
  - rdata=0; latched addr/wdata=0; round-robin last-owner register=1 (when compiled in).
- **Reset mid-ACCESS**: the transaction is abandoned. The next cycle shows mem_en=0 and no ack is ever issued for it. The memory word may or may not have been written.
- **Idle requester**: a req that drops before grant is simply not served. Dropping req after grant is illegal and the transaction still completes with an ack.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, grant goes to the port that was not the previous owner. The last-owner register updates at each grant and resets to 1, so port 0 wins the first tie.
  - A single requester is always granted regardless of history.
- Undefined: fixed priority, port 0 wins; no last-owner register exists.

Decomposition:
- **Package mem_arb_pkg**
  - State encoding: IDLE=2'b00, ACCESS=2'b01, RESP=2'b10.
  - Port ids: PORT_CPU=1'b0, PORT_AUX=1'b1.
  - Counter width constant sized for WAIT_CYC up to 15.
- **Sub-module arb_pick** (natural): combinational winner selection from m0_req, m1_req and last owner. It contains the MEM_ARB_ROUND_ROBIN_EN variant.

Test Plan:
- **Single read**: reset, then m0 read addr 0x10, mem returns 0xDEADBEEF, WAIT_CYC=2.
  - mem_en high in cycles 1-3; m0_ack=1 in cycle 4 with m0_rdata=0xDEADBEEF; m1_ack stays 0.
- **Single write**: m1 write addr 0x20, data 0x12345678.
  - mem_we=1 with mem_addr=0x20 and mem_wdata=0x12345678 for 3 cycles; m1_ack in cycle 4; rdata unchanged.
- **Simultaneous requests, fixed priority** (macro off): both request in the same cycle.
  - Port 0 acked first (cycle 4); port 1 granted next IDLE (cycle 5), acked cycle 9.
- **Alternation** (macro on): both hold req continuously for 4 transactions.
  - grant sequence 0,1,0,1; each ack spaced 5 cycles apart.
- **Reset mid-operation**: reset asserted in the 2nd ACCESS cycle.
  - Next cycle state IDLE, mem_en=0, no ack for the aborted request; a later m0 read completes normally.
- **Zero wait states**: WAIT_CYC=0, m0 read.
  - Exactly one mem_en cycle; ack in cycle 2.
